// File: rtl/comp_pkg.sv
// Shared types and constants for the completion-stage arbiter.
// Optional feature macro used by this slice: COMP_STATS_EN (broadcast/stall/occupancy counters).
package comp_pkg;

  localparam int NUM_FU_DFLT     = 3;
  localparam int CDB_W_DFLT      = 2;
  localparam int FIFO_DEPTH_DFLT = 4;
  localparam int PREG_W_DFLT     = 6;

  // One memory source plus the ALU result sources.
  localparam int NUM_SRC = NUM_FU_DFLT + 1;

  // A completed result as it travels through the arbiter and overflow buffer.
  typedef struct packed {
    logic [31:0]            data;
    logic [31:0]            pc;
    logic [PREG_W_DFLT-1:0] preg;
    logic                   lsq;
  } comp_entry_t;

  // Highest buffer occupancy at which a worst-case burst of nsrc new results
  // still fits after cdbw entries drain in the same cycle.
  function automatic int ready_thresh(int depth, int nsrc, int cdbw);
    return depth - nsrc + cdbw;
  endfunction

endpackage

// File: rtl/complete_arbiter_if.sv
// Result-source / CDB bundle of the completion arbiter.
// Optional feature macro used by this slice: COMP_STATS_EN (stats ports stay outside the bundle).
interface complete_arbiter_if #(
  parameter int NUM_FU = comp_pkg::NUM_SRC - 1,
  parameter int CDB_W  = comp_pkg::CDB_W_DFLT,
  parameter int PREG_W = comp_pkg::PREG_W_DFLT
);
  logic                     flush;
  logic                     mem_valid;
  logic                     mem_lsq;
  logic [31:0]              mem_data;
  logic [31:0]              mem_pc;
  logic [PREG_W-1:0]        mem_preg;
  logic [NUM_FU-1:0]        fu_valid;
  logic [32*NUM_FU-1:0]     fu_data;
  logic [32*NUM_FU-1:0]     fu_pc;
  logic [PREG_W*NUM_FU-1:0] fu_preg;
  logic                     in_ready;
  logic [CDB_W-1:0]         cdb_valid;
  logic [32*CDB_W-1:0]      cdb_data;
  logic [32*CDB_W-1:0]      cdb_pc;
  logic [PREG_W*CDB_W-1:0]  cdb_preg;
  logic [CDB_W-1:0]         cdb_lsq;

  modport master (
    output flush, mem_valid, mem_lsq, mem_data, mem_pc, mem_preg,
    output fu_valid, fu_data, fu_pc, fu_preg,
    input  in_ready, cdb_valid, cdb_data, cdb_pc, cdb_preg, cdb_lsq
  );

  modport slave (
    input  flush, mem_valid, mem_lsq, mem_data, mem_pc, mem_preg,
    input  fu_valid, fu_data, fu_pc, fu_preg,
    output in_ready, cdb_valid, cdb_data, cdb_pc, cdb_preg, cdb_lsq
  );
endinterface

// File: rtl/comp_fifo.sv
// Multi-push / multi-pop circular buffer holding results that lost CDB arbitration.
// Optional feature macro used by this slice: COMP_STATS_EN (no effect in this file).
module comp_fifo
  import comp_pkg::*;
#(
  parameter int N_PUSH = 4,
  parameter int N_POP  = 2,
  parameter int DEPTH  = 4,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW     = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic [CW-1:0] push_cnt,
  input  comp_entry_t   push_data [N_PUSH],
  input  logic [CW-1:0] pop_cnt,
  output comp_entry_t   rd_data [N_POP],
  output logic [CW-1:0] count
);

  comp_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap modulo DEPTH so non power-of-two depths stay correct.
  function automatic logic [AW-1:0] wrap(int p);
    return AW'(p % DEPTH);
  endfunction

  // Control state: flush and reset win over any push/pop; count moves by the net change.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wrap(int'(wr_ptr) + int'(push_cnt));
      rd_ptr <= wrap(int'(rd_ptr) + int'(pop_cnt));
      count  <= count - pop_cnt + push_cnt;
    end
  end

  // Storage: entries are written in order starting at the write pointer.
  always_ff @(posedge clk) begin
    if (rstn && !flush) begin
      for (int i = 0; i < N_PUSH; i++) begin
        if (i < int'(push_cnt)) mem[wrap(int'(wr_ptr) + i)] <= push_data[i];
      end
    end
  end

  // The oldest N_POP entries are always visible to the arbiter.
  always_comb begin
    for (int j = 0; j < N_POP; j++) rd_data[j] = mem[wrap(int'(rd_ptr) + j)];
  end

endmodule

// File: rtl/complete_arbiter.sv
// Completion-stage arbiter: merges the load result and ALU results onto CDB_W
// registered broadcast slots, oldest first, buffering losers in comp_fifo.
// Optional feature macro: COMP_STATS_EN adds saturating stat_bcast/stat_stall/stat_maxocc.
module complete_arbiter #(
  parameter int NUM_FU     = comp_pkg::NUM_FU_DFLT,
  parameter int CDB_W      = comp_pkg::CDB_W_DFLT,
  parameter int FIFO_DEPTH = comp_pkg::FIFO_DEPTH_DFLT,
  parameter int PREG_W     = comp_pkg::PREG_W_DFLT
) (
  input logic clk,
  input logic rstn,
  complete_arbiter_if.slave bus
`ifdef COMP_STATS_EN
  ,
  output logic [31:0] stat_bcast,
  output logic [31:0] stat_stall,
  output logic [31:0] stat_maxocc
`endif
);
  import comp_pkg::*;

  localparam int N_SRC = NUM_FU + 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int EPW   = PREG_W_DFLT;

  logic [N_SRC-1:0] req;
  comp_entry_t      new_ent  [N_SRC];
  comp_entry_t      push_ent [N_SRC];
  comp_entry_t      head     [CDB_W];
  comp_entry_t      slot     [CDB_W];
  comp_entry_t      slot_p0  [CDB_W];
  logic [CDB_W-1:0] slot_vld;
  logic [CDB_W-1:0] vld_p0;
  logic [CW-1:0]    count;
  logic [CW-1:0]    push_cnt;
  logic [CW-1:0]    pop_cnt;
  logic             in_ready;
  logic             accept;

  // Ready depends only on the registered count, so it never glitches.
  assign in_ready     = int'(count) <= ready_thresh(FIFO_DEPTH, N_SRC, CDB_W);
  assign accept       = in_ready && !bus.flush;
  assign bus.in_ready = in_ready;

  // Unpack the sources into candidate entries: memory first, then fu0..fuN-1.
  always_comb begin
    req[0]          = bus.mem_valid | bus.mem_lsq;
    new_ent[0].data = bus.mem_data;
    new_ent[0].pc   = bus.mem_pc;
    new_ent[0].preg = EPW'(bus.mem_preg);
    new_ent[0].lsq  = bus.mem_lsq;
    for (int f = 0; f < NUM_FU; f++) begin
      req[f+1]          = bus.fu_valid[f];
      new_ent[f+1].data = bus.fu_data[32*f +: 32];
      new_ent[f+1].pc   = bus.fu_pc[32*f +: 32];
      new_ent[f+1].preg = EPW'(bus.fu_preg[PREG_W*f +: PREG_W]);
      new_ent[f+1].lsq  = 1'b0;
    end
  end

  // Oldest-first selection: buffered heads take slots first, new requests fill
  // the rest, and whatever is left is pushed in candidate order.
  always_comb begin
    int pops;
    int pos;
    int npush;
    pops     = (int'(count) < CDB_W) ? int'(count) : CDB_W;
    pos      = pops;
    npush    = 0;
    slot_vld = '0;
    for (int s = 0; s < CDB_W; s++) slot[s] = '0;
    for (int j = 0; j < N_SRC; j++) push_ent[j] = '0;
    for (int s = 0; s < CDB_W; s++) begin
      if (s < pops) begin
        slot[s]     = head[s];
        slot_vld[s] = 1'b1;
      end
    end
    for (int k = 0; k < N_SRC; k++) begin
      if (accept && req[k]) begin
        for (int s = 0; s < CDB_W; s++) begin
          if (pos == s) begin
            slot[s]     = new_ent[k];
            slot_vld[s] = 1'b1;
          end
        end
        for (int j = 0; j < N_SRC; j++) begin
          if (pos - CDB_W == j) push_ent[j] = new_ent[k];
        end
        if (pos >= CDB_W) npush = npush + 1;
        pos = pos + 1;
      end
    end
    push_cnt = CW'(npush);
    pop_cnt  = CW'(pops);
  end

  comp_fifo #(
    .N_PUSH (N_SRC),
    .N_POP  (CDB_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (bus.flush),
    .push_cnt  (push_cnt),
    .push_data (push_ent),
    .pop_cnt   (pop_cnt),
    .rd_data   (head),
    .count     (count)
  );

  // ---- stage p0: registered CDB broadcast ----
  always_ff @(posedge clk) begin
    if (!rstn || bus.flush) begin
      vld_p0  <= '0;
      slot_p0 <= '{default: '0};
    end else begin
      vld_p0  <= slot_vld;
      slot_p0 <= slot;
    end
  end

  // Pack the registered slots onto the bus.
  always_comb begin
    bus.cdb_valid = vld_p0;
    bus.cdb_data  = '0;
    bus.cdb_pc    = '0;
    bus.cdb_preg  = '0;
    bus.cdb_lsq   = '0;
    for (int s = 0; s < CDB_W; s++) begin
      bus.cdb_data[32*s +: 32]         = slot_p0[s].data;
      bus.cdb_pc[32*s +: 32]           = slot_p0[s].pc;
      bus.cdb_preg[PREG_W*s +: PREG_W] = PREG_W'(slot_p0[s].preg);
      bus.cdb_lsq[s]                   = slot_p0[s].lsq;
    end
  end

  // Upstream must hold off while not ready; such requests are dropped.
  a_no_req_when_busy: assert property (@(posedge clk) disable iff (!rstn || bus.flush)
    in_ready || !(|req));

`ifdef COMP_STATS_EN
  function automatic logic [31:0] sat_add(logic [31:0] a, logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

  // Saturating statistics, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_bcast  <= '0;
      stat_stall  <= '0;
      stat_maxocc <= '0;
    end else begin
      stat_bcast  <= sat_add(stat_bcast, bus.flush ? 32'd0 : 32'($countones(slot_vld)));
      stat_stall  <= sat_add(stat_stall, {31'd0, !in_ready});
      if (32'(count) > stat_maxocc) stat_maxocc <= 32'(count);
    end
  end
`endif

endmodule

// File: tb/tb_complete_arbiter.sv
// Scoreboard bench for complete_arbiter: a queue-based reference model predicts
// each cycle's CDB slots; a negedge monitor compares the DUT against it.
module tb_complete_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  complete_arbiter_if bus ();

`ifdef COMP_STATS_EN
  logic [31:0] stat_bcast, stat_stall, stat_maxocc;
`endif

  complete_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef COMP_STATS_EN
    ,
    .stat_bcast  (stat_bcast),
    .stat_stall  (stat_stall),
    .stat_maxocc (stat_maxocc)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic [31:0] pc;
    logic [5:0]  preg;
    logic        lsq;
  } ent_t;

  typedef struct {
    logic [1:0]  v;
    logic [63:0] d;
    logic [63:0] pc;
    logic [11:0] preg;
    logic [1:0]  lsq;
    logic        rdy;
    int          cnt;
  } exp_t;

  ent_t pend[$];
  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int m_bcast = 0, m_stall = 0, m_max = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, req);
  endtask

  // Monitor: one expectation per clock edge, compared away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cdb_valid", 64'(bus.cdb_valid), 64'(e.v));
      check("cdb_data", 64'(bus.cdb_data), e.d);
      check("cdb_pc", 64'(bus.cdb_pc), e.pc);
      check("cdb_preg", 64'(bus.cdb_preg), 64'(e.preg));
      check("cdb_lsq", 64'(bus.cdb_lsq), 64'(e.lsq));
      check("in_ready", 64'(bus.in_ready), 64'(e.rdy));
      check("fifo_count", 64'(dut.count), 64'(e.cnt));
    end
  end

  // Drive one cycle of inputs and predict the CDB contents after the next edge.
  task automatic step(input bit fl, input bit rs, input bit mv_i, input bit ml_i,
                      input logic [31:0] mdata, input logic [31:0] mpc,
                      input logic [5:0] mpreg, input logic [2:0] fv_i,
                      input logic [95:0] fpcs);
    exp_t e;
    ent_t x;
    bit rdy_b, mv, ml;
    logic [2:0] fv;
    logic [95:0] fdata;
    logic [17:0] fpreg;
    int sz_b;
    sz_b  = pend.size();
    rdy_b = (sz_b <= 2);
    mv = mv_i; ml = ml_i; fv = fv_i;
    if (!fl && !rs && !rdy_b) begin
      mv = 0; ml = 0; fv = '0;
    end
    fdata = {$urandom, $urandom, $urandom};
    fpreg = 18'($urandom);
    rstn          = !rs;
    bus.flush     = fl;
    bus.mem_valid = mv;
    bus.mem_lsq   = ml;
    bus.mem_data  = mdata;
    bus.mem_pc    = mpc;
    bus.mem_preg  = mpreg;
    bus.fu_valid  = fv;
    bus.fu_data   = fdata;
    bus.fu_pc     = fpcs;
    bus.fu_preg   = fpreg;
    e.v = '0; e.d = '0; e.pc = '0; e.preg = '0; e.lsq = '0;
    if (rs) begin
      pend.delete();
      m_bcast = 0; m_stall = 0; m_max = 0;
    end else begin
      if (!rdy_b) m_stall++;
      if (sz_b > m_max) m_max = sz_b;
      if (fl) pend.delete();
      else begin
        if (mv || ml) pend.push_back('{mdata, mpc, mpreg, ml});
        for (int i = 0; i < 3; i++)
          if (fv[i]) pend.push_back('{fdata[32*i +: 32], fpcs[32*i +: 32], fpreg[6*i +: 6], 1'b0});
        for (int s = 0; s < 2; s++) begin
          if (pend.size() > 0) begin
            x = pend.pop_front();
            e.v[s] = 1'b1;
            e.d[32*s +: 32] = x.d;
            e.pc[32*s +: 32] = x.pc;
            e.preg[6*s +: 6] = x.preg;
            e.lsq[s] = x.lsq;
            m_bcast++;
          end
        end
      end
    end
    e.rdy = (pend.size() <= 2);
    e.cnt = pend.size();
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 32'd0, 32'd0, 6'd0, 3'b000, 96'd0);
  endtask

  task automatic burst4();
    step(0, 0, 0, 1, $urandom, 32'h10, 6'($urandom), 3'b111, {32'h1C, 32'h18, 32'h14});
  endtask

  initial begin
    int guard;
    bus.flush = 0; bus.mem_valid = 0; bus.mem_lsq = 0; bus.mem_data = '0;
    bus.mem_pc = '0; bus.mem_preg = '0; bus.fu_valid = '0; bus.fu_data = '0;
    bus.fu_pc = '0; bus.fu_preg = '0;

    // reset
    step(0, 1, 1, 0, 32'h1, 32'h2, 6'd3, 3'b101, 96'd7);
    step(0, 1, 0, 0, 32'd0, 32'd0, 6'd0, 3'b000, 96'd0);

    // single load
    step(0, 0, 1, 0, 32'hDEADBEEF, 32'h40, 6'd5, 3'b000, 96'd0);
    idle();

    // four simultaneous: two broadcast now, two buffered
    burst4();
    idle();
    idle();

    // back-to-back bursts while ready: occupancy reaches 4, ready drops
    repeat (6) burst4();
    repeat (3) idle();

    // build count=3 then flush with every input valid
    burst4();
    step(0, 0, 1, 0, $urandom, 32'h50, 6'd9, 3'b011, {32'h0, 32'h58, 32'h54});
    step(1, 0, 1, 1, $urandom, 32'h60, 6'd1, 3'b111, {32'h6C, 32'h68, 32'h64});
    idle();

    // reset with count=2
    burst4();
    step(0, 1, 1, 0, $urandom, 32'h70, 6'd2, 3'b111, {32'h7C, 32'h78, 32'h74});
    idle();

    // randomized traffic with occasional flush and reset
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 40) == 0, ($urandom % 100) == 0, $urandom % 2, ($urandom % 4) == 0,
           $urandom, $urandom, 6'($urandom), 3'($urandom), {$urandom, $urandom, $urandom});
    end

    // drain model and DUT with idle cycles
    guard = 0;
    while (pend.size() > 0 && guard < 10) begin
      idle();
      guard++;
    end
    idle();
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
`ifdef COMP_STATS_EN
    check("stat_bcast", 64'(stat_bcast), 64'(m_bcast));
    check("stat_stall", 64'(stat_stall), 64'(m_stall));
    check("stat_maxocc", 64'(stat_maxocc), 64'(m_max));
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/complete_arbiter.md
# complete_arbiter

Completion-stage arbiter that sits directly downstream of the MEM/Complete pipeline register. It merges the load result (from memory or LSQ forwarding) with the ALU functional-unit results onto a fixed number of common-data-bus (CDB) broadcast slots per cycle. Results that lose arbitration are held in an internal FIFO. The registered CDB outputs feed the ROB complete bits and the reservation-station wakeup logic.

## Interface
- NUM_FU, default 3: number of ALU result sources, in addition to the single memory source.
- CDB_W, default 2: broadcast slots per cycle. Must satisfy 1 ≤ CDB_W ≤ NUM_FU+1.
- FIFO_DEPTH, default 4: overflow buffer entries. Must satisfy FIFO_DEPTH ≥ NUM_FU+1−CDB_W.
- PREG_W, default 6: physical-register tag width.
- clk  in  1  single clock; everything is on its rising edge.
- rstn  in  1  reset, synchronous, active-low.
- flush  in  1  pipeline flush; drops all buffered and newly arriving results.
- mem_valid  in  1  load data valid from memory.
- mem_lsq  in  1  load data forwarded from LSQ.
- mem_data  in  32  load data.
- mem_pc  in  32  load PC.
- mem_preg  in  PREG_W  load destination tag.
- fu_valid  in  NUM_FU  per-FU result valid.
- fu_data  in  32*NUM_FU  packed FU results; FU i occupies bits [32i+31:32i].
- fu_pc  in  32*NUM_FU  packed FU PCs.
- fu_preg  in  PREG_W*NUM_FU  packed FU destination tags.
- in_ready  out  1  sources may present results this cycle.
- cdb_valid  out  CDB_W  per-slot broadcast valid.
- cdb_data  out  32*CDB_W  per-slot result.
- cdb_pc  out  32*CDB_W  per-slot PC.
- cdb_preg  out  PREG_W*CDB_W  per-slot destination tag.
- cdb_lsq  out  CDB_W  set when the slot carries an LSQ-forwarded load.

## Operation
- Memory source request: mem_valid | mem_lsq. If both are set, the result is treated as one load with lsq flag = mem_lsq.
- Candidate order each cycle is oldest first:
  - FIFO entries, head first.
  - Then the memory source.
  - Then fu0 … fu(NUM_FU−1).
- The first CDB_W candidates are registered onto cdb slots 0..CDB_W−1 in that order. Unused slots have cdb_valid=0, and their data/pc/preg/lsq fields are driven to 0.
- New requests not granted a slot are pushed into the FIFO in candidate order during the same cycle.
- FIFO pops = min(count, CDB_W). Next count = count − pops + overflow pushes.
- in_ready = (count ≤ FIFO_DEPTH − (NUM_FU+1) + CDB_W). It is derived combinationally from the registered count only, so it is glitch-free. With the defaults, in_ready is 1 when count ≤ 2.
- Sources must not assert any valid while in_ready=0. Upstream issue logic gates on in_ready. A violation is a protocol error: an assertion fires and the request is dropped.
- Write and read pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is a separate register, log2(FIFO_DEPTH)+1 bits wide.
- flush:
  - Clears the FIFO (pointers and count to 0).
  - Ignores all inputs in that cycle.
  - Registers all cdb_valid=0 at the next edge.
  - Takes priority over any push or pop in the same cycle.

## Timing
- Latency: an input sampled at edge N appears on cdb at edge N+1 if it wins a slot. A buffered result waits one extra cycle per cycle of backlog ahead of it.
- Values after reset (rstn=0 sampled at an edge):
  - All cdb outputs = 0.
  - FIFO empty, count=0.
  - in_ready=1 after that edge.
- Reset asserted mid-operation behaves like flush, and additionally clears the stats counters.
- Full FIFO (count=FIFO_DEPTH) with the defaults forces in_ready=0. It drains CDB_W entries per cycle.
- Simultaneous push and pop when full: legal. The net count change is computed, never an overflow.
- A FIFO entry always wins over a new request, which preserves completion order per source.

## Configuration
- COMP_STATS_EN defined:
  - Adds 32-bit output ports stat_bcast (total valid slots broadcast), stat_stall (cycles with in_ready=0) and stat_maxocc (peak count, zero-extended).
  - Counters saturate at their maximum value and clear on reset.
- COMP_STATS_EN undefined:
  - These ports and counters do not exist.
  - Functional behaviour is identical.

## Structure
- Shared package comp_pkg holds:
  - A comp_entry_t struct {data[31:0], pc[31:0], preg[PREG_W−1:0], lsq}.
  - The constant NUM_SRC = NUM_FU+1.
  - The ready-threshold function.
- One sub-module, comp_fifo:
  - Multi-push/multi-pop circular buffer over comp_entry_t.
  - Up to NUM_SRC pushes and CDB_W pops per cycle, with flush.
- The arbiter itself is combinational candidate selection plus registered cdb outputs.

## Test plan
- Single load: mem_valid=1, pc=0x40, data=0xDEADBEEF, preg=5 → one cycle later cdb slot0 valid, pc=0x40, data=0xDEADBEEF, lsq=0; slot1 invalid.
- Four simultaneous (mem_lsq=1 pc=0x10, fu0 pc=0x14, fu1 pc=0x18, fu2 pc=0x1C) → cycle+1 slots carry 0x10 (lsq=1) and 0x14; count=2. Cycle+2 slots carry 0x18 and 0x1C; count=0.
- Back-to-back full bursts of four results every cycle while in_ready=1 → count reaches 4 and in_ready drops to 0. No request is lost, and PCs appear in candidate order.
- Flush with count=3 and new inputs valid → next cycle all cdb_valid=0, count=0, in_ready=1.
- Reset asserted while count=2 → next edge: outputs 0, count=0. With COMP_STATS_EN defined, stat counters read 0.
- With COMP_STATS_EN defined: 10 single-result cycles → stat_bcast=10, stat_stall=0, stat_maxocc=0.
